mainram_bus_initiator: RTL and testbench
========================================

Name: mainram_bus_initiator

Overview:
- Requester-side bridge that drives the word-addressed main RAM port (write enable, word address, write data, byte enables, combinational read data).
- Accepts byte-addressed 8/16/32-bit single or burst requests from the CPU/DMA arbiter over a valid/ready handshake.
- Inserts programmable wait states, steers byte lanes, and returns one response pulse per beat.

Parameters:
- ADDR_W, 14, RAM word-address width; byte address width is ADDR_W+2.
- WAIT_CYCLES, 2, wait cycles before each RAM access beat; 0 is legal.
- BURST_W, 3, width of burst length field; max beats = 2^BURST_W.

Ports:
- clock  in  1  single clock, all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_write  in  1  1=write, 0=read.
- req_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word).
- req_addr  in  ADDR_W+2  byte address of first beat.
- req_wdata  in  32  write data, low-justified; reused for every beat.
- req_len  in  BURST_W  beats minus 1.
- rsp_valid  out  1  one-cycle pulse per completed beat.
- rsp_rdata  out  32  read data, low-justified, zero-extended; 0 for writes.
- rsp_last  out  1  with rsp_valid on final beat.
- ram_wren  out  1  RAM write strobe.
- ram_address  out  ADDR_W  RAM word address.
- ram_data  out  32  RAM write data.
- ram_byteena  out  4  RAM byte lanes.
- ram_q  in  32  RAM read data, combinational from ram_address.

Behaviour:
- Reset (async, reset_n low): state=IDLE; req_ready=1; rsp_valid, rsp_last, ram_wren=0; rsp_rdata, ram_address, ram_data, ram_byteena=0; beat and wait counters=0. Reset mid-burst drops the burst without a response or write.
- States: IDLE, WAIT, ACCESS.
  - IDLE: on req_valid&&req_ready, latch write, size, address, wdata, len. Go to WAIT if WAIT_CYCLES>0, else ACCESS.
  - WAIT: count WAIT_CYCLES cycles, then go to ACCESS.
  - ACCESS: exactly one cycle. Drive ram_address = current byte address >> 2, plus ram_byteena and ram_data. ram_wren=1 only if write. For reads, capture the steered ram_q into rsp_rdata at the end of the cycle. Next state: IDLE if the beat is the last, else WAIT (or ACCESS if WAIT_CYCLES=0).
- Outputs outside ACCESS: ram_wren=0 and ram_byteena=0; ram_address holds its last value.
- Response timing: rsp_valid (and rsp_last on the final beat) is registered and asserts the cycle after ACCESS.
- Latency, WAIT_CYCLES=2: accept at cycle 0, WAIT at cycles 1-2, ACCESS at cycle 3, rsp_valid at cycle 4. Beat period is WAIT_CYCLES+1.
- req_ready rises the cycle after the last ACCESS. A new request may be accepted in the same cycle as the final rsp_valid.
- Alignment: half ignores addr[0]; word ignores addr[1:0].
- Byte enables:
  - byte: 1 << addr[1:0].
  - half: 0011 or 1100 by addr[1].
  - word: 1111.
- Write data lanes: byte is replicated ×4; half is replicated ×2; word is passed as-is.
- Read extract: byte lane addr[1:0] or half lane addr[1], shifted to bit 0 and zero-extended.
- Burst address: increments by 1/2/4 bytes per beat. Word address wraps modulo 2^ADDR_W with no error.
- Responses cannot be stalled; there is no backpressure.

Optional Feature:
- MAINRAM_MISALIGN_ROTATE_EN defined: word reads with addr[1:0]!=0 return ram_q rotated right by 8*addr[1:0] (ARM LDR semantics). Byte enables and writes are unchanged.
- Undefined: word reads return ram_q unrotated.

Decomposition:
- Shared package mainram_pkg:
  - access-size enum (SZ_BYTE, SZ_HALF, SZ_WORD).
  - state enum (ST_IDLE, ST_WAIT, ST_ACCESS).
  - constant for the data width of 32.
- One combinational sub-module, mainram_lane_steer. Inputs: size, addr[1:0], wdata, ram_q. Outputs: byteena, replicated wdata, extracted rdata, including the rotate option.

Test Plan:
- Word write addr 0x0010, data 0xDEADBEEF, WAIT_CYCLES=2 -> ram_wren at cycle 3, ram_address=0x0004, byteena=1111; rsp_valid, rsp_last at cycle 4; req_ready back at cycle 4.
- Byte write addr 0x0013, data 0x5A -> byteena=1000, ram_data=0x5A5A5A5A. A following byte read of 0x0013 returns rsp_rdata=0x0000005A.
- Half read addr 0x0006 with RAM word 1 = 0x12345678 -> byteena=1100, rsp_rdata=0x00001234.
- Word read burst len=3 from byte addr 0xFFF8 (ADDR_W=14) -> ram_address sequence 0x3FFE, 0x3FFF, 0x0000, 0x0001. rsp_valid pulses 3 cycles apart; rsp_last only on the 4th.
- Reset asserted during the 2nd beat's WAIT of a write burst -> all outputs 0 immediately; no further ram_wren; req_ready=1 after reset release.
- Word read addr 0x0001 with RAM word 0 = 0x11223344 -> with MAINRAM_MISALIGN_ROTATE_EN, rsp_rdata=0x44112233; without it, 0x11223344.

Source files
------------

// File: rtl/mainram_pkg.sv
// rtl/mainram_pkg.sv - shared types and helpers for the main RAM bus initiator
package mainram_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  // The reserved size code behaves as a word access.
  function automatic size_t decode_size(input logic [1:0] code);
    case (code)
      2'd0:    decode_size = SZ_BYTE;
      2'd1:    decode_size = SZ_HALF;
      default: decode_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input size_t sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mainram_bus_initiator_if.sv
// rtl/mainram_bus_initiator_if.sv - request/response handshake between arbiter and RAM initiator
interface mainram_bus_initiator_if #(
  parameter int ADDR_W  = 14,
  parameter int BURST_W = 3
);
  import mainram_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [1:0]          req_size;
  logic [ADDR_W+1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [BURST_W-1:0]  req_len;
  logic                rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_last;

  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata, req_len,
    input  req_ready, rsp_valid, rsp_rdata, rsp_last
  );

  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata, req_len,
    output req_ready, rsp_valid, rsp_rdata, rsp_last
  );

endinterface

// File: rtl/mainram_lane_steer.sv
// rtl/mainram_lane_steer.sv - byte-lane enables, write replication and read extraction
// Optional MAINRAM_MISALIGN_ROTATE_EN: misaligned word reads rotate right by 8*addr[1:0].
module mainram_lane_steer
  import mainram_pkg::*;
(
  input  size_t              size,
  input  logic [1:0]         addr_lo,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [DATA_W-1:0]  ram_q,
  output logic [3:0]         byteena,
  output logic [DATA_W-1:0]  wdata_rep,
  output logic [DATA_W-1:0]  rdata
);

  logic [4:0] sh;
  logic [DATA_W-1:0] q_shr;

  assign sh    = {addr_lo, 3'b000};
  assign q_shr = ram_q >> sh;

  always_comb begin
    byteena   = 4'b0000;
    wdata_rep = '0;
    rdata     = '0;
    case (size)
      SZ_BYTE: begin
        byteena   = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata     = {24'd0, q_shr[7:0]};
      end
      SZ_HALF: begin
        byteena   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata     = {16'd0, (addr_lo[1] ? ram_q[31:16] : ram_q[15:0])};
      end
      default: begin
        byteena   = 4'b1111;
        wdata_rep = wdata;
`ifdef MAINRAM_MISALIGN_ROTATE_EN
        // A shift by 32 yields zero, so the aligned case collapses to ram_q.
        rdata     = q_shr | (ram_q << (6'd32 - {1'b0, sh}));
`else
        rdata     = ram_q;
`endif
      end
    endcase
  end

endmodule

// File: rtl/mainram_bus_initiator.sv
// rtl/mainram_bus_initiator.sv - wait-stated single/burst initiator for the word-addressed main RAM
// Optional MAINRAM_MISALIGN_ROTATE_EN is handled inside mainram_lane_steer.
module mainram_bus_initiator
  import mainram_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int WAIT_CYCLES = 2,
  parameter int BURST_W     = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  mainram_bus_initiator_if.slave bus,
  output logic                 ram_wren,
  output logic [ADDR_W-1:0]    ram_address,
  output logic [DATA_W-1:0]    ram_data,
  output logic [3:0]           ram_byteena,
  input  logic [DATA_W-1:0]    ram_q
);

  localparam int AW  = ADDR_W + 2;
  localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t               state, state_nxt;
  logic                 wr_q;
  size_t                size_q;
  logic [AW-1:0]        addr_q, addr_nxt;
  logic [DATA_W-1:0]    wdata_q;
  logic [BURST_W-1:0]   len_q, beat_q;
  logic [WCW-1:0]       wait_q;
  logic                 rsp_valid_q, rsp_last_q;
  logic [DATA_W-1:0]    rsp_rdata_q;

  logic                 accept, in_access, last_beat;
  logic [3:0]           lane_be;
  logic [DATA_W-1:0]    lane_wdata, lane_rdata;

  assign accept    = bus.req_valid && (state == ST_IDLE);
  assign in_access = (state == ST_ACCESS);
  assign last_beat = (beat_q == len_q);

  mainram_lane_steer u_steer (
    .size      (size_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .ram_q     (ram_q),
    .byteena   (lane_be),
    .wdata_rep (lane_wdata),
    .rdata     (lane_rdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          addr_nxt  = bus.req_addr;
          state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        // Byte address wraps naturally, which wraps the word address too.
        addr_nxt = addr_q + AW'(size_bytes(size_q));
        if (last_beat)             state_nxt = ST_IDLE;
        else if (WAIT_CYCLES > 0)  state_nxt = ST_WAIT;
        else                       state_nxt = ST_ACCESS;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      addr_q      <= '0;
      wdata_q     <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      wait_q      <= '0;
      ram_address <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      addr_q <= addr_nxt;
      if (accept) begin
        wr_q    <= bus.req_write;
        size_q  <= decode_size(bus.req_size);
        wdata_q <= bus.req_wdata;
        len_q   <= bus.req_len;
        beat_q  <= '0;
      end else if (in_access) begin
        beat_q  <= beat_q + BURST_W'(1);
      end
      wait_q <= ((state == ST_WAIT) && (wait_q != WAIT_LAST)) ? wait_q + WCW'(1) : '0;
      // ram_address only moves on entry to ACCESS and holds otherwise.
      if (state_nxt == ST_ACCESS) ram_address <= addr_nxt[AW-1:2];
      rsp_valid_q <= in_access;
      rsp_last_q  <= in_access && last_beat;
      if (in_access) rsp_rdata_q <= wr_q ? '0 : lane_rdata;
    end
  end

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign ram_wren      = in_access && wr_q;
  assign ram_byteena   = in_access ? lane_be : 4'b0000;
  assign ram_data      = in_access ? lane_wdata : '0;

endmodule

// File: tb/tb_mainram_bus_initiator.sv
// tb/tb_mainram_bus_initiator.sv - directed self-checking bench for mainram_bus_initiator
module tb_mainram_bus_initiator;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ram_wren;
  logic [13:0] ram_address;
  logic [31:0] ram_data;
  logic [3:0]  ram_byteena;
  logic [31:0] ram_q;

  logic [31:0] mem [0:16383];
  logic        pre_we = 1'b0;
  logic [13:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  int n_cmp = 0;
  int n_fail = 0;

  logic        lg_wren  [32];
  logic [13:0] lg_addr  [32];
  logic [31:0] lg_data  [32];
  logic [3:0]  lg_be    [32];
  logic        lg_rv    [32];
  logic        lg_rl    [32];
  logic [31:0] lg_rd    [32];
  logic        lg_rdy   [32];

  mainram_bus_initiator_if #(.ADDR_W(14), .BURST_W(3)) bif ();

  mainram_bus_initiator #(.ADDR_W(14), .WAIT_CYCLES(2), .BURST_W(3)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bif),
    .ram_wren    (ram_wren),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_byteena (ram_byteena),
    .ram_q       (ram_q)
  );

  always #5 clock = ~clock;

  assign ram_q = mem[ram_address];

  always @(posedge clock) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_wren)
      for (int b = 0; b < 4; b++)
        if (ram_byteena[b]) mem[ram_address][8*b +: 8] <= ram_data[8*b +: 8];
  end

  task automatic preload(input logic [13:0] a, input logic [31:0] d);
    @(negedge clock);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(negedge clock);
    pre_we = 1'b0;
  endtask

  // Drives one request in the "cycle 0" window and logs cycles 1..ncyc at the falling edge.
  task automatic issue(input logic w, input logic [1:0] sz, input logic [15:0] a,
                       input logic [31:0] d, input logic [2:0] l, input int ncyc, input bit now);
    if (!now) @(negedge clock);
    bif.req_write = w; bif.req_size = sz; bif.req_addr = a;
    bif.req_wdata = d; bif.req_len = l; bif.req_valid = 1'b1;
    @(posedge clock);
    #1 bif.req_valid = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clock);
      lg_wren[k] = ram_wren;    lg_addr[k] = ram_address; lg_data[k] = ram_data;
      lg_be[k]   = ram_byteena; lg_rv[k]   = bif.rsp_valid; lg_rl[k] = bif.rsp_last;
      lg_rd[k]   = bif.rsp_rdata; lg_rdy[k] = bif.req_ready;
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (bif.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", bif.req_ready); end
    n_cmp++; if (bif.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", bif.rsp_valid); end
    n_cmp++; if (bif.rsp_last !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_last got %b want 0", bif.rsp_last); end
    n_cmp++; if (bif.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", bif.rsp_rdata); end
    n_cmp++; if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren got %b want 0", ram_wren); end
    n_cmp++; if (ram_address !== 14'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", ram_address); end
    n_cmp++; if (ram_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", ram_data); end
    n_cmp++; if (ram_byteena !== 4'h0) begin n_fail++; $display("FAIL reset_be got %b want 0", ram_byteena); end
  endtask

  task automatic test_word_write();
    issue(1'b1, 2'd2, 16'h0010, 32'hDEADBEEF, 3'd0, 5, 1'b0);
    n_cmp++; if (lg_wren[2] !== 1'b0) begin n_fail++; $display("FAIL ww_wren_c2 got %b want 0", lg_wren[2]); end
    n_cmp++; if (lg_wren[3] !== 1'b1) begin n_fail++; $display("FAIL ww_wren_c3 got %b want 1", lg_wren[3]); end
    n_cmp++; if (lg_wren[4] !== 1'b0) begin n_fail++; $display("FAIL ww_wren_c4 got %b want 0", lg_wren[4]); end
    n_cmp++; if (lg_addr[3] !== 14'h0004) begin n_fail++; $display("FAIL ww_addr got %h want 0004", lg_addr[3]); end
    n_cmp++; if (lg_be[3] !== 4'b1111) begin n_fail++; $display("FAIL ww_be got %b want 1111", lg_be[3]); end
    n_cmp++; if (lg_be[2] !== 4'b0000) begin n_fail++; $display("FAIL ww_be_wait got %b want 0000", lg_be[2]); end
    n_cmp++; if (lg_data[3] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ww_data got %h want deadbeef", lg_data[3]); end
    n_cmp++; if (lg_rv[3] !== 1'b0) begin n_fail++; $display("FAIL ww_rv_c3 got %b want 0", lg_rv[3]); end
    n_cmp++; if (lg_rv[4] !== 1'b1 || lg_rl[4] !== 1'b1) begin n_fail++; $display("FAIL ww_rsp_c4 got v%b l%b want v1 l1", lg_rv[4], lg_rl[4]); end
    n_cmp++; if (lg_rv[5] !== 1'b0) begin n_fail++; $display("FAIL ww_rv_c5 got %b want 0", lg_rv[5]); end
    n_cmp++; if (lg_rdy[3] !== 1'b0 || lg_rdy[4] !== 1'b1) begin n_fail++; $display("FAIL ww_ready got c3=%b c4=%b want c3=0 c4=1", lg_rdy[3], lg_rdy[4]); end
    n_cmp++; if (lg_rd[4] !== 32'h0) begin n_fail++; $display("FAIL ww_rdata got %h want 0", lg_rd[4]); end
    n_cmp++; if (lg_addr[5] !== 14'h0004) begin n_fail++; $display("FAIL ww_addr_hold got %h want 0004", lg_addr[5]); end
    n_cmp++; if (mem[4] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ww_mem got %h want deadbeef", mem[4]); end
  endtask

  task automatic test_byte_half();
    issue(1'b1, 2'd0, 16'h0013, 32'h0000005A, 3'd0, 5, 1'b0);
    n_cmp++; if (lg_be[3] !== 4'b1000) begin n_fail++; $display("FAIL bw_be got %b want 1000", lg_be[3]); end
    n_cmp++; if (lg_data[3] !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL bw_data got %h want 5a5a5a5a", lg_data[3]); end
    issue(1'b0, 2'd0, 16'h0013, 32'h0, 3'd0, 5, 1'b0);
    n_cmp++; if (lg_wren[3] !== 1'b0) begin n_fail++; $display("FAIL br_wren got %b want 0", lg_wren[3]); end
    n_cmp++; if (lg_rd[4] !== 32'h0000005A) begin n_fail++; $display("FAIL br_rdata got %h want 0000005a", lg_rd[4]); end
    preload(14'h0001, 32'h12345678);
    issue(1'b0, 2'd1, 16'h0006, 32'h0, 3'd0, 5, 1'b0);
    n_cmp++; if (lg_be[3] !== 4'b1100) begin n_fail++; $display("FAIL hr_be got %b want 1100", lg_be[3]); end
    n_cmp++; if (lg_addr[3] !== 14'h0001) begin n_fail++; $display("FAIL hr_addr got %h want 0001", lg_addr[3]); end
    n_cmp++; if (lg_rd[4] !== 32'h00001234) begin n_fail++; $display("FAIL hr_rdata got %h want 00001234", lg_rd[4]); end
    issue(1'b1, 2'd1, 16'h0009, 32'h0000BEEF, 3'd0, 5, 1'b0);
    n_cmp++; if (lg_be[3] !== 4'b0011) begin n_fail++; $display("FAIL hw_be got %b want 0011", lg_be[3]); end
    n_cmp++; if (lg_data[3] !== 32'hBEEFBEEF) begin n_fail++; $display("FAIL hw_data got %h want beefbeef", lg_data[3]); end
  endtask

  task automatic test_burst_wrap();
    logic [13:0] exp_a [4];
    logic [31:0] exp_d [4];
    exp_a[0] = 14'h3FFE; exp_a[1] = 14'h3FFF; exp_a[2] = 14'h0000; exp_a[3] = 14'h0001;
    exp_d[0] = 32'hA0A0A0A0; exp_d[1] = 32'hA1A1A1A1; exp_d[2] = 32'hA2A2A2A2; exp_d[3] = 32'hA3A3A3A3;
    for (int i = 0; i < 4; i++) preload(exp_a[i], exp_d[i]);
    issue(1'b0, 2'd2, 16'hFFF8, 32'h0, 3'd3, 14, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (lg_addr[3*i+3] !== exp_a[i]) begin n_fail++; $display("FAIL burst_addr%0d got %h want %h", i, lg_addr[3*i+3], exp_a[i]); end
      n_cmp++; if (lg_rv[3*i+4] !== 1'b1 || lg_rv[3*i+5] !== 1'b0) begin n_fail++; $display("FAIL burst_rv%0d got %b%b want 10", i, lg_rv[3*i+4], lg_rv[3*i+5]); end
      n_cmp++; if (lg_rl[3*i+4] !== (i == 3)) begin n_fail++; $display("FAIL burst_last%0d got %b want %b", i, lg_rl[3*i+4], (i == 3)); end
      n_cmp++; if (lg_rd[3*i+4] !== exp_d[i]) begin n_fail++; $display("FAIL burst_rdata%0d got %h want %h", i, lg_rd[3*i+4], exp_d[i]); end
    end
    n_cmp++; if (lg_rdy[12] !== 1'b0 || lg_rdy[13] !== 1'b1) begin n_fail++; $display("FAIL burst_ready got c12=%b c13=%b want 0/1", lg_rdy[12], lg_rdy[13]); end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 2'd2, 16'h0020, 32'h11111111, 3'd0, 4, 1'b0);
    n_cmp++; if (bif.rsp_valid !== 1'b1 || bif.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_overlap got v%b r%b want v1 r1", bif.rsp_valid, bif.req_ready); end
    issue(1'b0, 2'd2, 16'h0020, 32'h0, 3'd0, 5, 1'b1);
    n_cmp++; if (lg_addr[3] !== 14'h0008) begin n_fail++; $display("FAIL b2b_addr got %h want 0008", lg_addr[3]); end
    n_cmp++; if (lg_rv[4] !== 1'b1 || lg_rd[4] !== 32'h11111111) begin n_fail++; $display("FAIL b2b_rdata got v%b %h want v1 11111111", lg_rv[4], lg_rd[4]); end
  endtask

  task automatic test_reset_mid_burst();
    int wr_seen;
    int rv_seen;
    wr_seen = 0; rv_seen = 0;
    preload(14'h0010, 32'h0);
    preload(14'h0011, 32'h0);
    issue(1'b1, 2'd2, 16'h0040, 32'hCAFEF00D, 3'd3, 3, 1'b0);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    n_cmp++; if (bif.rsp_valid !== 1'b0 || ram_wren !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctl got v%b w%b want 0 0", bif.rsp_valid, ram_wren); end
    n_cmp++; if (ram_address !== 14'h0 || ram_byteena !== 4'h0 || ram_data !== 32'h0) begin n_fail++; $display("FAIL rst_mid_ram got a%h b%b d%h want 0", ram_address, ram_byteena, ram_data); end
    n_cmp++; if (bif.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got %b want 1", bif.req_ready); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (ram_wren) wr_seen++;
      if (bif.rsp_valid) rv_seen++;
    end
    n_cmp++; if (wr_seen != 0 || rv_seen != 0) begin n_fail++; $display("FAIL rst_mid_quiet got wr=%0d rsp=%0d want 0 0", wr_seen, rv_seen); end
    n_cmp++; if (mem[14'h0010] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rst_mid_beat0 got %h want cafef00d", mem[14'h0010]); end
    n_cmp++; if (mem[14'h0011] !== 32'h0) begin n_fail++; $display("FAIL rst_mid_beat1 got %h want 0", mem[14'h0011]); end
    n_cmp++; if (bif.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready_after got %b want 1", bif.req_ready); end
  endtask

  task automatic test_misalign_word();
    logic [31:0] exp;
`ifdef MAINRAM_MISALIGN_ROTATE_EN
    exp = 32'h44112233;
`else
    exp = 32'h11223344;
`endif
    preload(14'h0000, 32'h11223344);
    issue(1'b0, 2'd2, 16'h0001, 32'h0, 3'd0, 5, 1'b0);
    n_cmp++; if (lg_be[3] !== 4'b1111) begin n_fail++; $display("FAIL mis_be got %b want 1111", lg_be[3]); end
    n_cmp++; if (lg_rd[4] !== exp) begin n_fail++; $display("FAIL mis_rdata got %h want %h", lg_rd[4], exp); end
    issue(1'b0, 2'd3, 16'h0000, 32'h0, 3'd0, 5, 1'b0);
    n_cmp++; if (lg_be[3] !== 4'b1111 || lg_rd[4] !== 32'h11223344) begin n_fail++; $display("FAIL rsvd_size got b%b %h want 1111 11223344", lg_be[3], lg_rd[4]); end
  endtask

  initial begin
    bif.req_valid = 1'b0; bif.req_write = 1'b0; bif.req_size = 2'd0;
    bif.req_addr = '0; bif.req_wdata = '0; bif.req_len = '0;
    reset_n = 1'b0;
    test_reset();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    preload(14'h0004, 32'h0);
    test_word_write();
    test_byte_half();
    test_burst_wrap();
    test_back_to_back();
    test_reset_mid_burst();
    test_misalign_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
